ycbcr_convert_arbiter: RTL and testbench
========================================

YCBCR_CONVERT_ARBITER -- requirements
Module: ycbcr_convert_arbiter

Interface
REQ-001 Parameter BURST, default 4: max pixels granted to one requester before re-arbitration; legal range 1..15.
REQ-002 iClk  input  1  sole clock; all state updates on rising edge.
REQ-003 iRst  input  1  asynchronous, active-high reset.
REQ-004 iValid  input  2  per-requester pixel valid; bit k belongs to requester k.
REQ-005 oReady  output  2  per-requester accept; transfer on requester k when iValid[k] && oReady[k].
REQ-006 iRGB0, iRGB1  input  24 each  {R,G,B} 8 bits each, for requester 0 and 1.
REQ-007 oValid  output  1  converted pixel valid.
REQ-008 iReady  input  1  downstream accept; output transfer when oValid && iReady.
REQ-009 oYCbCr  output  24  {Y,Cb,Cr} 8 bits each.
REQ-010 oId  output  1  requester index of the pixel on oYCbCr.
REQ-011 oBusy  output  1  high when the state is not IDLE or either pipeline stage holds data.

Function
REQ-012 FSM states IDLE, OWN0, OWN1; oReady[k] high only in OWNk, and only when stage 1 can accept.
REQ-013 oReady SHALL NOT depend combinationally on iValid.
REQ-014 IDLE: if any iValid, next state OWNk, with k = the requester not served last (RR pointer); if only one is valid, that one.
REQ-015 OWNk: 4-bit burst counter increments per transfer on requester k.
REQ-016 OWNk exit condition: counter reaches BURST on a transfer, or iValid[k] low in a cycle.
REQ-017 On exit: if the other requester is valid -> OWN(other); else if iValid[k] is still high -> stay OWNk; else -> IDLE.
REQ-018 On exit: the counter clears, and the RR pointer records k.
REQ-019 Both requesters valid continuously: grants alternate in bursts of exactly BURST pixels, starting with requester 0 after reset.
REQ-020 Stage 1 registers the selected RGB and id on transfer.
REQ-021 Stage 2 registers the converted {Y,Cb,Cr} and id.
REQ-022 Conversion math: Y=16+((66R+129G+25B)>>8), Cb=128+((-38R-74G+112B)>>8), Cr=128+((112R-94G-18B)>>8).
REQ-023 Arithmetic width: >=16-bit intermediates; results truncated to 8 bits.
REQ-024 Stage 2 loads when it is empty or iReady is high; stage 1 can accept when it is empty or stage 2 loads.
REQ-025 Throughput: one pixel per cycle sustained.
REQ-026 Latency: a pixel accepted at edge N appears on oValid/oYCbCr after edge N+1.
REQ-027 With iReady low, oValid/oYCbCr/oId SHALL hold stable; no pixel dropped or duplicated; oReady falls once both stages are full.
REQ-028 Output order: pixels leave in acceptance order; oId is always correct.

Reset
REQ-029 iRst high: state IDLE, counter 0, RR pointer set to favour requester 0, both stage valids 0.
REQ-030 iRst high: oReady=0, oValid=0, oYCbCr=0, oId=0, oBusy=0, all immediately, without a clock edge.
REQ-031 Reset mid-operation discards in-flight pixels; the first grant after release follows REQ-014.

Structure
REQ-032 Shared package ycbcr_pkg holds the FSM state enum, the pixel width constant (24), and the BURST default.
REQ-033 The conversion is one instance of the team's rgb_to_ycbcr converter between stages 1 and 2; no other sub-module.

Verification
REQ-034 Only requester 0 valid, iRGB0=000000, iReady=1 -> after 2 cycles oYCbCr=108080, oId=0, then one pixel per cycle.
REQ-035 Requester 1 sends FFFFFF, iReady=1 -> oYCbCr=EB8080, oId=1.
REQ-036 Both valid continuously, BURST=4, iReady=1 -> oId sequence 0,0,0,0,1,1,1,1,0...
REQ-037 Stalls: iReady low for 5 cycles mid-stream -> oReady low after 2 further accepts; output held stable; no loss or duplication on resume.
REQ-038 Requester 0 drops iValid after 2 pixels while requester 1 is valid -> next grant goes to requester 1; counter restarts at 0.
REQ-039 iRst asserted with both stages full -> oValid=0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared types and constants for the two-requester RGB to YCbCr converter.
// No logic of its own.
package ycbcr_pkg;

  localparam int PIX_W     = 24;
  localparam int BURST_DEF = 4;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

endpackage

// File: rtl/rgb_to_ycbcr.sv
// Combinational BT.601 studio-range RGB to YCbCr converter, zero latency.
// No handshake: the surrounding pipeline decides when the result is captured.
module rgb_to_ycbcr
  import ycbcr_pkg::*;
(
  input  pixel_t iRgb,
  output pixel_t oYcc
);

  logic signed [17:0] r, g, b;
  logic signed [17:0] ySum, cbSum, crSum;
  logic        [7:0]  y, cb, cr;

  assign r = 18'(iRgb[23:16]);
  assign g = 18'(iRgb[15:8]);
  assign b = 18'(iRgb[7:0]);

  // Chroma sums go negative, so the divide by 256 is an arithmetic shift (floor).
  assign ySum  = 18'sd66  * r + 18'sd129 * g + 18'sd25 * b;
  assign cbSum = 18'sd112 * b - 18'sd38  * r - 18'sd74 * g;
  assign crSum = 18'sd112 * r - 18'sd94  * g - 18'sd18 * b;

  assign y  = 8'(18'sd16  + (ySum  >>> 8));
  assign cb = 8'(18'sd128 + (cbSum >>> 8));
  assign cr = 8'(18'sd128 + (crSum >>> 8));

  assign oYcc = {y, cb, cr};

endmodule

// File: rtl/ycbcr_convert_arbiter.sv
// Round-robin burst arbiter for two RGB sources feeding a 2-stage converter; accept to oValid in 2 edges.
// Backpressure: stage 2 holds while iReady is low, oReady drops once both stages are full.
module ycbcr_convert_arbiter
  import ycbcr_pkg::*;
#(
  parameter int BURST = BURST_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [1:0]       iValid,
  output logic [1:0]       oReady,
  input  logic [PIX_W-1:0] iRGB0,
  input  logic [PIX_W-1:0] iRGB1,
  output logic             oValid,
  input  logic             iReady,
  output logic [PIX_W-1:0] oYCbCr,
  output logic             oId,
  output logic             oBusy
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  arbState_t   state, stateNext;
  logic [3:0]  burstCnt, burstCntNext;
  logic        rrLast, rrLastNext;

  logic        s1Vld, s1Id;
  pixel_t      s1Rgb;
  logic        s2Vld, s2Id;
  pixel_t      s2Ycc;
  pixel_t      convYcc;

  logic        s2Load, s1Open;
  logic        cur, curValid, othValid, burstEnd;
  logic        xfer, xferId;

  assign s2Load = !s2Vld || iReady;
  assign s1Open = !s1Vld || s2Load;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      burstCnt <= 4'd0;
      rrLast   <= 1'b1;
    end else begin
      state    <= stateNext;
      burstCnt <= burstCntNext;
      rrLast   <= rrLastNext;
    end
  end

  always_comb begin
    stateNext    = state;
    burstCntNext = burstCnt;
    rrLastNext   = rrLast;
    oReady       = 2'b00;
    cur          = 1'b0;
    curValid     = 1'b0;
    othValid     = 1'b0;
    burstEnd     = 1'b0;
    xfer         = 1'b0;
    xferId       = 1'b0;
    case (state)
      IDLE: begin
        if (iValid == 2'b11)  stateNext = rrLast ? OWN0 : OWN1;
        else if (iValid[0])   stateNext = OWN0;
        else if (iValid[1])   stateNext = OWN1;
      end
      OWN0, OWN1: begin
        cur      = (state == OWN1);
        curValid = cur ? iValid[1] : iValid[0];
        othValid = cur ? iValid[0] : iValid[1];
        // Grant is a function of state and pipeline space only, never of iValid.
        oReady   = cur ? {s1Open, 1'b0} : {1'b0, s1Open};
        xfer     = curValid && s1Open;
        xferId   = cur;
        burstEnd = xfer && ((burstCnt + 4'd1) == BURST_L);
        if (burstEnd || !curValid) begin
          burstCntNext = 4'd0;
          rrLastNext   = cur;
          if (othValid)      stateNext = cur ? OWN0 : OWN1;
          else if (curValid) stateNext = state;
          else               stateNext = IDLE;
        end else if (xfer) begin
          burstCntNext = burstCnt + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  rgb_to_ycbcr uConv (
    .iRgb (s1Rgb),
    .oYcc (convYcc)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1Vld <= 1'b0;
      s1Id  <= 1'b0;
      s1Rgb <= '0;
      s2Vld <= 1'b0;
      s2Id  <= 1'b0;
      s2Ycc <= '0;
    end else begin
      if (s2Load) begin
        s2Vld <= s1Vld;
        if (s1Vld) begin
          s2Ycc <= convYcc;
          s2Id  <= s1Id;
        end
      end
      if (s1Open) begin
        s1Vld <= xfer;
        if (xfer) begin
          s1Rgb <= xferId ? iRGB1 : iRGB0;
          s1Id  <= xferId;
        end
      end
    end
  end

  assign oValid = s2Vld;
  assign oYCbCr = s2Ycc;
  assign oId    = s2Id;
  assign oBusy  = (state != IDLE) || s1Vld || s2Vld;

endmodule

// File: tb/tb_ycbcr_convert_arbiter.sv
// Directed bench for ycbcr_convert_arbiter with an in-order scoreboard on the output stream.
module tb_ycbcr_convert_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [1:0]  iValid;
  logic [1:0]  oReady;
  logic [23:0] iRGB0, iRGB1;
  logic        oValid;
  logic        iReady;
  logic [23:0] oYCbCr;
  logic        oId;
  logic        oBusy;

  logic        autoRgb = 1'b0;
  logic [23:0] fixRgb0 = 24'h000000;
  logic [23:0] fixRgb1 = 24'h000000;
  logic [23:0] genRgb0 = 24'h102030;
  logic [23:0] genRgb1 = 24'h405060;
  logic        pend0 = 1'b0;
  logic        pend1 = 1'b0;

  int          nChecks = 0;
  int          nFails  = 0;
  int          outCnt  = 0;
  int          acc0Cnt = 0;
  int          acc1Cnt = 0;
  logic [24:0] expQ[$];
  logic        idLog[$];
  int          accLog[$];
  logic        holdVld = 1'b0;
  logic [24:0] holdDat;

  assign iRGB0 = autoRgb ? genRgb0 : fixRgb0;
  assign iRGB1 = autoRgb ? genRgb1 : fixRgb1;

  always #5 iClk = ~iClk;

  ycbcr_convert_arbiter #(.BURST(4)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iRGB0  (iRGB0),
    .iRGB1  (iRGB1),
    .oValid (oValid),
    .iReady (iReady),
    .oYCbCr (oYCbCr),
    .oId    (oId),
    .oBusy  (oBusy)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] toYcc(input logic [23:0] p);
    int r, g, b, y, cb, cr;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    y  = 16  + ((66 * r + 129 * g + 25 * b) >>> 8);
    cb = 128 + ((112 * b - 38 * r - 74 * g) >>> 8);
    cr = 128 + ((112 * r - 94 * g - 18 * b) >>> 8);
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  // Handshakes seen at a negedge complete on the following posedge.
  always @(negedge iClk) begin
    logic [24:0] e;
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (iRst) begin
      expQ.delete();
      holdVld = 1'b0;
    end else begin
      if (holdVld) begin
        checkVal("hold_vld", 32'(oValid), 32'd1);
        checkVal("hold_dat", 32'({oId, oYCbCr}), 32'(holdDat));
      end
      holdVld = oValid && !iReady;
      holdDat = {oId, oYCbCr};
      if (oValid && iReady) begin
        outCnt++;
        idLog.push_back(oId);
        checkVal("out_queue_nonempty", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkVal("out_pix", 32'({oId, oYCbCr}), 32'(e));
        end
      end
      if (iValid[0] && oReady[0]) begin
        pend0 = 1'b1;
        acc0Cnt++;
        accLog.push_back(0);
        expQ.push_back({1'b0, toYcc(iRGB0)});
      end
      if (iValid[1] && oReady[1]) begin
        pend1 = 1'b1;
        acc1Cnt++;
        accLog.push_back(1);
        expQ.push_back({1'b1, toYcc(iRGB1)});
      end
    end
  end

  always @(posedge iClk) begin
    #1;
    if (pend0) genRgb0 = genRgb0 + 24'h1F3A57;
    if (pend1) genRgb1 = genRgb1 + 24'h2B71C9;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge iClk);
    #2;
  endtask

  task automatic doReset();
    iRst   = 1'b1;
    iValid = 2'b00;
    iReady = 1'b1;
    cyc(2);
    iRst   = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 30 && oBusy; i++) cyc(1);
    checkVal(tag, 32'(oBusy), 32'd0);
  endtask

  task automatic sendPix(input int k, input logic [23:0] rgb, input logic [23:0] expYcc);
    autoRgb = 1'b0;
    if (k == 1) fixRgb1 = rgb;
    else        fixRgb0 = rgb;
    iReady = 1'b1;
    iValid = (k == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i < 10 && !oValid; i++) cyc(1);
    checkVal("vec_vld", 32'(oValid), 32'd1);
    checkVal("vec_pix", 32'({oId, oYCbCr}), 32'({k[0], expYcc}));
    iValid = 2'b00;
    waitIdle("vec_idle");
  endtask

  logic [23:0] vecRgb[4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
  logic [23:0] vecExp[4] = '{24'hEB8080, 24'h515AEF, 24'h903622, 24'h28EF6E};
  int          vecReq[4] = '{1, 0, 1, 0};
  int          expAcc[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int snap;
    int accSnap;
    iRst   = 1'b1;
    iValid = 2'b00;
    iReady = 1'b0;
    #2;
    checkVal("rst_ready", 32'(oReady), 32'd0);
    checkVal("rst_valid", 32'(oValid), 32'd0);
    checkVal("rst_ycc",   32'(oYCbCr), 32'd0);
    checkVal("rst_id",    32'(oId),    32'd0);
    checkVal("rst_busy",  32'(oBusy),  32'd0);

    // Single requester, black pixels: grant, 2-edge latency, then full rate.
    doReset();
    fixRgb0 = 24'h000000;
    iValid  = 2'b01;
    cyc(1);
    checkVal("lat_grant", 32'(oReady), 32'd1);
    checkVal("lat_vld0",  32'(oValid), 32'd0);
    cyc(1);
    checkVal("lat_vld1",  32'(oValid), 32'd0);
    checkVal("lat_busy",  32'(oBusy),  32'd1);
    cyc(1);
    checkVal("lat_vld2",  32'(oValid), 32'd1);
    checkVal("lat_pix",   32'({oId, oYCbCr}), 32'h0108080);
    snap = outCnt;
    cyc(8);
    checkVal("rate_r0", 32'(outCnt - snap), 32'd8);
    iValid = 2'b00;
    waitIdle("idle_r0");

    for (int v = 0; v < 4; v++) sendPix(vecReq[v], vecRgb[v], vecExp[v]);

    // Both requesters continuously valid: bursts of four starting with requester 0.
    doReset();
    autoRgb = 1'b1;
    idLog.delete();
    iValid  = 2'b11;
    cyc(30);
    for (int i = 0; i < 16; i++)
      checkVal("burst_id", (i < idLog.size()) ? 32'(idLog[i]) : 32'hFFFF, 32'((i / 4) % 2));

    // Downstream stall mid-stream.
    accSnap = acc0Cnt + acc1Cnt;
    iReady  = 1'b0;
    cyc(3);
    checkVal("stall_rdy", 32'(oReady), 32'd0);
    checkVal("stall_vld", 32'(oValid), 32'd1);
    cyc(2);
    checkVal("stall_acc", 32'((acc0Cnt + acc1Cnt - accSnap) <= 2), 32'd1);
    iReady = 1'b1;
    cyc(2);
    snap = outCnt;
    cyc(10);
    checkVal("resume_rate", 32'(outCnt - snap), 32'd10);
    iValid = 2'b00;
    waitIdle("idle_burst");
    checkVal("sb_empty_burst", 32'(expQ.size()), 32'd0);

    // Requester 0 drops after two pixels; requester 1 gets a fresh full burst.
    doReset();
    accLog.delete();
    snap   = acc0Cnt;
    iValid = 2'b11;
    for (int i = 0; i < 20 && (acc0Cnt - snap) < 2; i++) begin
      @(posedge iClk);
      #1;
    end
    checkVal("drop_seen2", 32'(acc0Cnt - snap), 32'd2);
    iValid[0] = 1'b0;
    for (int i = 0; i < 10 && oReady != 2'b10; i++) cyc(1);
    checkVal("drop_grant1", 32'(oReady), 32'h2);
    iValid = 2'b11;
    cyc(14);
    for (int i = 0; i < 10; i++)
      checkVal("drop_seq", (i < accLog.size()) ? 32'(accLog[i]) : 32'hFFFF, 32'(expAcc[i]));
    iValid = 2'b00;
    waitIdle("idle_drop");

    // Reset with both stages full.
    iReady = 1'b0;
    iValid = 2'b01;
    cyc(6);
    checkVal("full_vld", 32'(oValid), 32'd1);
    checkVal("full_rdy", 32'(oReady), 32'd0);
    iRst = 1'b1;
    #1;
    checkVal("mrst_vld",  32'(oValid), 32'd0);
    checkVal("mrst_rdy",  32'(oReady), 32'd0);
    checkVal("mrst_ycc",  32'(oYCbCr), 32'd0);
    checkVal("mrst_busy", 32'(oBusy),  32'd0);
    cyc(2);
    iRst = 1'b0;
    accLog.delete();
    idLog.delete();
    iReady = 1'b1;
    iValid = 2'b11;
    cyc(6);
    checkVal("mrst_first_acc", (accLog.size() > 0) ? 32'(accLog[0]) : 32'hFFFF, 32'd0);
    checkVal("mrst_first_out", (idLog.size() > 0) ? 32'(idLog[0]) : 32'hFFFF, 32'd0);
    iValid = 2'b00;
    waitIdle("idle_end");
    checkVal("sb_empty_end", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
